// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants and pointer helpers for the FIFO pointer controller.
//   DEFAULT_ADDR_WIDTH : default RAM address width (depth = 2**ADDR_WIDTH)
//   ptr_next(ptr)      : wrap-bit pointer increment; the caller truncates to its pointer width
//   ptr_diff(wr, rd)   : pointer difference; the caller truncates, which gives the modulo result
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;

    function automatic logic [31:0] ptr_next(input logic [31:0] ptr);
        return ptr + 32'd1;
    endfunction

    function automatic logic [31:0] ptr_diff(input logic [31:0] wr, input logic [31:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if
//   Handshake bundle between a FIFO client, the full/empty comparator and fifo_ptr_ctrl.
//   slave  : controller side (takes requests and full/empty, drives pointers, strobes and status)
//   master : client/comparator side
//   Optional feature macro: FIFO_WATERMARK_EN adds almost_full / almost_empty.
interface fifo_ptr_ctrl_if import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  write_req;
    logic                  read_req;
    logic                  full;
    logic                  empty;
    logic                  err_clr;
    logic [ADDR_WIDTH:0]   write_addr;
    logic [ADDR_WIDTH:0]   read_addr;
    logic                  write_ena;
    logic                  read_ena;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_WATERMARK_EN
    logic                  almost_full;
    logic                  almost_empty;
`endif

    modport slave (
        input  write_req, read_req, full, empty, err_clr,
        output write_addr, read_addr, write_ena, read_ena, rd_valid,
               fill_level, overflow, underflow
`ifdef FIFO_WATERMARK_EN
       ,output almost_full, almost_empty
`endif
    );

    modport master (
        output write_req, read_req, full, empty, err_clr,
        input  write_addr, read_addr, write_ena, read_ena, rd_valid,
               fill_level, overflow, underflow
`ifdef FIFO_WATERMARK_EN
       ,input  almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/fifo_ptr_counter.sv
// fifo_ptr_counter
//   Enable-gated wrap-bit pointer register with asynchronous active-low reset.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (pointer returns to 0)
//   en_i  : advance the pointer by one at the next edge
//   ptr_o : registered pointer; MSB is the wrap bit, the low bits address the RAM
module fifo_ptr_counter import fifo_pkg::*; #(
    parameter int PTR_W = DEFAULT_ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Truncating the increment to PTR_W wraps all-ones back to 0 and toggles the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = PTR_W'(ptr_next(32'(ptr_q)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
//   FIFO write/read pointer controller. Gates requests with the external comparator's
//   full/empty, advances (ADDR_WIDTH+1)-bit wrap-bit pointers, drives RAM strobes,
//   reports fill level and sticky overflow/underflow.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (release synchronised outside this block)
//   bus   : fifo_ptr_ctrl_if.slave -- write_req/read_req/full/empty/err_clr in;
//           write_addr/read_addr/write_ena/read_ena/rd_valid/fill_level/overflow/underflow out
//   Optional feature macro: FIFO_WATERMARK_EN adds parameters AF_THRESH/AE_THRESH and
//   registered outputs almost_full/almost_empty.
module fifo_ptr_ctrl import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef FIFO_WATERMARK_EN
   ,parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 2
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_ptr_ctrl_if.slave  bus
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fill;
    logic          wr_en;
    logic          rd_en;
    logic          rd_valid_q;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;

    // Full and empty are never both true, so a simultaneous request at full keeps the
    // read and at empty keeps the write; no fall-through is possible.
    assign wr_en = bus.write_req & ~bus.full;
    assign rd_en = bus.read_req  & ~bus.empty;

    fifo_ptr_counter #(.PTR_W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (wr_en),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_counter #(.PTR_W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (rd_en),
        .ptr_o (rd_ptr)
    );

    assign fill = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr)));

    // A new error in the same cycle as err_clr must survive the clear.
    always_comb begin
        overflow_d  = (overflow_q  & ~bus.err_clr) | (bus.write_req & bus.full);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.read_req  & bus.empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_en;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_WATERMARK_EN
    localparam logic [PW-1:0] AF_P = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_P = PW'(AE_THRESH);

    logic [PW-1:0] fill_d;
    logic          almost_full_q;
    logic          almost_empty_q;

    // Flags are registered from the next-state fill so they change on the same edge as the pointers.
    assign fill_d = fill + PW'(wr_en) - PW'(rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (fill_d >= AF_P);
            almost_empty_q <= (fill_d <= AE_P);
        end
    end

    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`endif

    assign bus.write_addr = wr_ptr;
    assign bus.read_addr  = rd_ptr;
    assign bus.write_ena  = wr_en;
    assign bus.read_ena   = rd_en;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fill_level = fill;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl
//   Self-checking bench for fifo_ptr_ctrl at ADDR_WIDTH=2 (depth 4). The bench plays the
//   full/empty comparator from its own occupancy model and compares every DUT output
//   against counts of accepted writes/reads. With FIFO_WATERMARK_EN defined it also
//   checks almost_full/almost_empty with AF_THRESH=3, AE_THRESH=1.
module tb_fifo_ptr_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int PMASK = 7;   // pointers are AW+1 = 3 bits

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ptr_ctrl #(
        .ADDR_WIDTH (AW)
`ifdef FIFO_WATERMARK_EN
       ,.AF_THRESH  (3),
        .AE_THRESH  (1)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: total accepted writes/reads since reset, sticky flags, read latency.
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit m_ovf  = 1'b0;
    bit m_unf  = 1'b0;
    bit m_rdv  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Comparator stand-in driven from the model's occupancy.
    assign bus.full  = ((wr_cnt - rd_cnt) == DEPTH);
    assign bus.empty = (wr_cnt == rd_cnt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string where);
        int fill;
        fill = wr_cnt - rd_cnt;
        chk({where, ":write_addr"}, 32'(bus.write_addr), wr_cnt & PMASK);
        chk({where, ":read_addr"},  32'(bus.read_addr),  rd_cnt & PMASK);
        chk({where, ":fill_level"}, 32'(bus.fill_level), fill);
        chk({where, ":rd_valid"},   32'(bus.rd_valid),   32'(m_rdv));
        chk({where, ":overflow"},   32'(bus.overflow),   32'(m_ovf));
        chk({where, ":underflow"},  32'(bus.underflow),  32'(m_unf));
`ifdef FIFO_WATERMARK_EN
        chk({where, ":almost_full"},  32'(bus.almost_full),  32'(fill >= 3));
        chk({where, ":almost_empty"}, 32'(bus.almost_empty), 32'(fill <= 1));
`endif
    endtask

    // One clock: drive at the falling edge, check strobes mid-cycle, check state after the edge.
    task automatic step(input bit w, input bit r, input bit c);
        int fill;
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        bus.write_req = w;
        bus.read_req  = r;
        bus.err_clr   = c;
        #1;
        fill  = wr_cnt - rd_cnt;
        acc_w = w && (fill != DEPTH);
        acc_r = r && (fill != 0);
        chk("write_ena",  32'(bus.write_ena),  32'(acc_w));
        chk("read_ena",   32'(bus.read_ena),   32'(acc_r));
        chk("fill_comb",  32'(bus.fill_level), fill);
        @(posedge clk);
        #1;
        m_ovf  = (m_ovf && !c) || (w && fill == DEPTH);
        m_unf  = (m_unf && !c) || (r && fill == 0);
        m_rdv  = acc_r;
        wr_cnt = wr_cnt + int'(acc_w);
        rd_cnt = rd_cnt + int'(acc_r);
        check_regs("step");
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rdv  = 1'b0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic reset_now();
        #2;
        bus.write_req = 1'b0;
        bus.read_req  = 1'b0;
        bus.err_clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        chk("async_rst:write_ena", 32'(bus.write_ena), 32'd0);
        chk("async_rst:read_ena",  32'(bus.read_ena),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.write_req = 1'b0;
        bus.read_req  = 1'b0;
        bus.err_clr   = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill from empty to full, then push once more while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("full:write_addr_100", 32'(bus.write_addr), 32'd4);
        chk("full:fill_4",         32'(bus.fill_level), 32'd4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Simultaneous request while full: only the read goes through.
        step(1'b1, 1'b1, 1'b0);
        chk("full_rw:read_addr", 32'(bus.read_addr),  32'd1);
        chk("full_rw:fill",      32'(bus.fill_level), 32'd3);

        // Drain, read while empty, err_clr colliding with a new underflow, then clear.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Simultaneous request while empty: only the write goes through.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Mid-burst reset with a read-valid in flight.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        reset_now();

        // Nine interleaved write/read pairs wrap both pointers to 3'b001.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        chk("wrap:write_addr_001", 32'(bus.write_addr), 32'd1);
        chk("wrap:read_addr_001",  32'(bus.read_addr),  32'd1);

        // Random traffic: write-biased phase, then read-biased phase.
        for (int i = 0; i < 300; i++) begin
            int wp;
            wp = (i < 150) ? 70 : 30;
            step($urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
